// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator types, default width and magnitude helper
package calc_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  // Magnitude of a sign-extended two's-complement value; callers truncate to
  // their operand width, where |-2^(W-1)| still fits as unsigned.
  function automatic logic [31:0] abs_val(input logic signed [31:0] v);
    logic [31:0] r;
    if (v[31]) r = unsigned'(-v);
    else       r = unsigned'(v);
    return r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - one-bit half adder cell
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/mul_add_stage.sv
// rtl/mul_add_stage.sv - WIDTH+1-bit conditional adder for the shift-and-add step
module mul_add_stage
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] addend,
  input  logic             en,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH-1:0] gated;
  logic [WIDTH-1:0] carry;

  // With en low the addend is zeroed, so the chain simply passes acc_hi through.
  assign gated = addend & {WIDTH{en}};

  half_adder u_ha0 (
    .a (acc_hi[0]),
    .b (gated[0]),
    .s (sum[0]),
    .c (carry[0])
  );

  for (genvar i = 1; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a  (acc_hi[i]),
      .b  (gated[i]),
      .ci (carry[i-1]),
      .s  (sum[i]),
      .co (carry[i])
    );
  end

  // Carry-out is kept as the extra top bit so the shift never loses it.
  assign sum[WIDTH] = carry[WIDTH-1];

endmodule

// File: rtl/seq_signed_multiplier.sv
// rtl/seq_signed_multiplier.sv - sequential signed multiplier; SEQ_MUL_FIT_EN adds the fit output
module seq_signed_multiplier
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
`ifdef SEQ_MUL_FIT_EN
  ,
  output logic               fit
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod_val;
  logic [CW-1:0]      count;
  logic               neg;
  logic [WIDTH:0]     add_sum;
  logic               last_step;

  assign mag_a_in  = WIDTH'(abs_val({{(32-WIDTH){a[WIDTH-1]}}, a}));
  assign mag_b_in  = WIDTH'(abs_val({{(32-WIDTH){b[WIDTH-1]}}, b}));
  assign last_step = (count == CW'(WIDTH - 1));
  assign prod_val  = neg ? (~acc + 1'b1) : acc;

  mul_add_stage #(.WIDTH(WIDTH)) u_add (
    .acc_hi (acc[2*WIDTH-1:WIDTH]),
    .addend (mag_a),
    .en     (mag_b[0]),
    .sum    (add_sum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: IDLE waits for start, CALC runs WIDTH steps, SIGN is one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_step) state_next = SIGN;
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    case (state)
      CALC, SIGN: busy = 1'b1;
      default:    busy = 1'b0;
    endcase
  end

  // Datapath: operand capture, shift-and-add steps, and signed result publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_a <= '0;
      mag_b <= '0;
      acc   <= '0;
      count <= '0;
      neg   <= 1'b0;
      prod  <= '0;
      done  <= 1'b0;
`ifdef SEQ_MUL_FIT_EN
      fit   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_a <= mag_a_in;
            mag_b <= mag_b_in;
            neg   <= a[WIDTH-1] ^ b[WIDTH-1];
            acc   <= '0;
            count <= '0;
          end
        end
        CALC: begin
          acc   <= {add_sum, acc[WIDTH-1:1]};
          mag_b <= mag_b >> 1;
          count <= count + 1'b1;
        end
        SIGN: begin
          prod <= prod_val;
          done <= 1'b1;
`ifdef SEQ_MUL_FIT_EN
          fit  <= (&prod_val[2*WIDTH-1:WIDTH-1]) | ~(|prod_val[2*WIDTH-1:WIDTH-1]);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// tb/tb_seq_signed_multiplier.sv - self-checking bench for seq_signed_multiplier
module tb_seq_signed_multiplier;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [2*W-1:0] prod;
  logic         fit_w;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_signed_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .prod  (prod)
`ifdef SEQ_MUL_FIT_EN
    ,
    .fit   (fit_w)
`endif
  );

`ifndef SEQ_MUL_FIT_EN
  assign fit_w = 1'b0;
`endif

  function automatic int sval(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  // Drives one operation from IDLE and observes 8 edges after acceptance.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output logic [2*W-1:0] p, output logic f,
                        output int lat, output int nd, output bit moved);
    logic [2*W-1:0] prev;
    prev = prod;
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    lat = -1; nd = 0; p = prod; f = fit_w; moved = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (lat < 0) begin lat = k; p = prod; f = fit_w; end
        prev = prod;
      end else if (prod !== prev) begin
        moved = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (prod !== 8'h00) begin miscompares++; $display("FAIL reset_prod: got %h expected 00", prod); end
`ifdef SEQ_MUL_FIT_EN
    vectors++; if (fit_w !== 1'b0) begin miscompares++; $display("FAIL reset_fit: got %b expected 0", fit_w); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    logic [2*W-1:0] p; logic f; int lat, nd, seen; bit moved;
    run_op(4'd2, 4'd3, p, f, lat, nd, moved);
    vectors++; if (p !== 8'h06) begin miscompares++; $display("FAIL pre_reset_prod: got %h expected 06", p); end
    a = 4'd3; b = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b expected 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
    vectors++; if (prod !== 8'h00) begin miscompares++; $display("FAIL abort_prod: got %h expected 00", prod); end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_done_count: got %0d expected 0", seen); end
    run_op(4'd3, 4'd5, p, f, lat, nd, moved);
    vectors++; if (p !== 8'h0F) begin miscompares++; $display("FAIL post_reset_prod: got %h expected 0f", p); end
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL post_reset_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_signs();
    logic [W-1:0] xa [0:2]; logic [W-1:0] xb [0:2]; logic [2*W-1:0] xp [0:2];
    logic [2*W-1:0] p; logic f; int lat, nd; bit moved;
    xa = '{4'hD, 4'h3, 4'hD}; xb = '{4'h5, 4'hB, 4'hB}; xp = '{8'hF1, 8'hF1, 8'h0F};
    for (int i = 0; i < 3; i++) begin
      run_op(xa[i], xb[i], p, f, lat, nd, moved);
      vectors++; if (p !== xp[i]) begin miscompares++; $display("FAIL sign_prod[%0d]: got %h expected %h", i, p, xp[i]); end
`ifdef SEQ_MUL_FIT_EN
      vectors++; if (f !== 1'b0) begin miscompares++; $display("FAIL sign_fit[%0d]: got %b expected 0", i, f); end
`endif
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0] xa [0:2]; logic [W-1:0] xb [0:2]; logic [2*W-1:0] xp [0:2];
    logic [2*W-1:0] p; logic f; int lat, nd; bit moved;
    xa = '{4'h8, 4'h8, 4'h7}; xb = '{4'h8, 4'h7, 4'h7}; xp = '{8'h40, 8'hC8, 8'h31};
    for (int i = 0; i < 3; i++) begin
      run_op(xa[i], xb[i], p, f, lat, nd, moved);
      vectors++; if (p !== xp[i]) begin miscompares++; $display("FAIL extreme_prod[%0d]: got %h expected %h", i, p, xp[i]); end
`ifdef SEQ_MUL_FIT_EN
      vectors++; if (f !== 1'b0) begin miscompares++; $display("FAIL extreme_fit[%0d]: got %b expected 0", i, f); end
`endif
    end
  endtask

  task automatic test_zero_one();
    logic [W-1:0] xa [0:1]; logic [W-1:0] xb [0:1]; logic [2*W-1:0] xp [0:1];
    logic [2*W-1:0] p; logic f; int lat, nd; bit moved;
    xa = '{4'h0, 4'hF}; xb = '{4'h8, 4'h1}; xp = '{8'h00, 8'hFF};
    for (int i = 0; i < 2; i++) begin
      run_op(xa[i], xb[i], p, f, lat, nd, moved);
      vectors++; if (p !== xp[i]) begin miscompares++; $display("FAIL zero_one_prod[%0d]: got %h expected %h", i, p, xp[i]); end
`ifdef SEQ_MUL_FIT_EN
      vectors++; if (f !== 1'b1) begin miscompares++; $display("FAIL zero_one_fit[%0d]: got %b expected 1", i, f); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int dk[$];
    logic [W-1:0] av, bv;
    logic [2*W-1:0] ep;
    av = W'($urandom); bv = W'($urandom);
    ep = 8'(sval(av) * sval(bv));
    a = av; b = bv; start = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      if (done) begin
        dk.push_back(k);
        vectors++; if (prod !== ep) begin miscompares++; $display("FAIL b2b_prod@%0d: got %h expected %h", k, prod, ep); end
      end
    end
    start = 1'b0;
    vectors++; if (dk.size() !== 4) begin miscompares++; $display("FAIL b2b_done_count: got %0d expected 4", dk.size()); end
    for (int i = 0; i < dk.size(); i++) begin
      vectors++; if (dk[i] !== 5 + 6 * i) begin miscompares++; $display("FAIL b2b_done_edge[%0d]: got %0d expected %0d", i, dk[i], 5 + 6 * i); end
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_busy_ignore();
    int nd, lat;
    bit moved;
    nd = 0; lat = -1; moved = 1'b0;
    a = 4'd3; b = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 4'd7; b = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 3; k <= 16; k++) begin
      @(posedge clk); #1;
      if (done) begin nd++; if (lat < 0) lat = k; end
      if (k >= 5 && prod !== 8'h0F) moved = 1'b1;
    end
    vectors++; if (nd !== 1) begin miscompares++; $display("FAIL ignore_done_count: got %0d expected 1", nd); end
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL ignore_latency: got %0d expected 5", lat); end
    vectors++; if (moved !== 1'b0) begin miscompares++; $display("FAIL ignore_prod_stable: got %b expected 0", moved); end
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv; logic [2*W-1:0] p, ep; logic f; int lat, nd; bit moved;
    for (int i = 0; i < 40; i++) begin
      av = W'($urandom); bv = W'($urandom);
      ep = 8'(sval(av) * sval(bv));
      run_op(av, bv, p, f, lat, nd, moved);
      vectors++; if (p !== ep) begin miscompares++; $display("FAIL random_prod a=%h b=%h: got %h expected %h", av, bv, p, ep); end
      vectors++; if (moved !== 1'b0) begin miscompares++; $display("FAIL random_prod_stable a=%h b=%h: got %b expected 0", av, bv, moved); end
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] av, bv; logic [2*W-1:0] p, ep; logic f, ef; int lat, nd, pv; bit moved;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        av = W'(i); bv = W'(j);
        pv = sval(av) * sval(bv);
        ep = 8'(pv);
        ef = (pv >= -(1 << (W - 1))) && (pv < (1 << (W - 1)));
        run_op(av, bv, p, f, lat, nd, moved);
        vectors++; if (p !== ep) begin miscompares++; $display("FAIL sweep_prod a=%h b=%h: got %h expected %h", av, bv, p, ep); end
        vectors++; if (lat !== 5) begin miscompares++; $display("FAIL sweep_latency a=%h b=%h: got %0d expected 5", av, bv, lat); end
        vectors++; if (nd !== 1) begin miscompares++; $display("FAIL sweep_done_count a=%h b=%h: got %0d expected 1", av, bv, nd); end
`ifdef SEQ_MUL_FIT_EN
        vectors++; if (f !== ef) begin miscompares++; $display("FAIL sweep_fit a=%h b=%h: got %b expected %b", av, bv, f, ef); end
`else
        if (f !== 1'b0 && ef === 1'bx) $display("unreachable");
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_calc();
    test_signs();
    test_extremes();
    test_zero_one();
    test_back_to_back();
    test_busy_ignore();
    test_random();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
